// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed N-digit seven-segment driver with shadow buffer and leading-zero blanking
module seg_scan_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blank_in,
  input  logic                lzb,
  input  logic                load,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                frame_done
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   dpm_q, blank_q;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d, fd_q;
  logic                tick, wrap, blank;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   upper_zero;
  // upper_zero[i]: every nibble from i up to the top digit is zero
  for (genvar i = 0; i < DIGITS; i++) begin : g_uz
    assign upper_zero[i] = data_q[4*DIGITS-1:4*i] == '0;
  end
  always_comb begin
    tick  = div_q == DIV_MAX;
    wrap  = tick && idx_q == IDX_MAX;
    div_d = tick ? '0 : div_q + 1'b1;
    idx_d = wrap ? '0 : tick ? idx_q + 1'b1 : idx_q;
    nib   = data_q[{idx_q, 2'b00} +: 4];
    blank = blank_q[idx_q] | (lzb & (idx_q != '0) & upper_zero[idx_q]);
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = blank ? 7'h7f : GLYPH[nib];
    dp_d  = blank | ~dpm_q[idx_q];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      dpm_q   <= '0;
      blank_q <= '0;
      an_q    <= '1;
      seg_q   <= '1;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      if (load) begin
        data_q  <= data;
        dpm_q   <= dp_in;
        blank_q <= blank_in;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fd_q  <= wrap;
    end
  end
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: vector table, corner sequences and random stimulus against an arithmetic scan model
module tb_seg_scan_display;
  localparam int D = 4;
  localparam int S = 4;
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dpi;
    logic [3:0]  blk;
    logic        lz;
    logic [27:0] seg;
    logic [3:0]  dpx;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0, blank_in = '0;
  logic        lzb = 1'b0, load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp, frame_done;
  int          pass_cnt = 0, total = 0;
  int          n = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0, m_blank = '0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;
  logic [6:0]  ref_glyph [16];
  vec_t        vecs [7];
  always #5 clk = ~clk;
  seg_scan_display #(.DIGITS(D), .SCAN_DIV(S), .DIV_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in), .blank_in(blank_in),
    .lzb(lzb), .load(load), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // After n running edges the digit index is (n/S)%D; outputs show the index held before the edge.
  task automatic cyc();
    int i;
    logic blk;
    logic [3:0] nb;
    if (!rst_n) begin
      n = 0; m_data = '0; m_dp = '0; m_blank = '0;
      e_an = '1; e_seg = '1; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      i = (n / S) % D;
      nb = 4'(m_data >> (4 * i));
      blk = m_blank[i] || (lzb && i != 0 && (m_data >> (4 * i)) == 0);
      e_an = ~(4'b1 << i);
      e_seg = blk ? 7'h7f : ref_glyph[nb];
      e_dp = blk || !m_dp[i];
      n++;
      e_fd = (n % (S * D)) == 0;
      if (load) begin m_data = data; m_dp = dp_in; m_blank = blank_in; end
    end
    @(posedge clk); #1;
    check("model_an", an, e_an);
    check("model_seg", seg, e_seg);
    check("model_dp", dp, e_dp);
    check("model_fd", frame_done, e_fd);
  endtask
  task automatic seek(input int ph, input int dg);
    int k;
    for (k = 0; k <= S * D && !(n % S == ph && (n / S) % D == dg); k++) cyc();
    check("seek", (n % S == ph && (n / S) % D == dg), 1);
  endtask
  initial begin
    ref_glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                  7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    vecs[0] = '{16'h1A3F, 4'b0100, 4'b0000, 1'b0, {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110}, 4'b1011};
    vecs[1] = '{16'h0040, 4'b0000, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b0011001, 7'b1000000}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
    vecs[3] = '{16'h1A3F, 4'b0001, 4'b0001, 1'b0, {7'b1111001, 7'b0001000, 7'b0110000, 7'b1111111}, 4'b1111};
    vecs[4] = '{16'h8765, 4'b1010, 4'b0000, 1'b1, {7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010}, 4'b0101};
    vecs[5] = '{16'h0B0C, 4'b0000, 4'b0000, 1'b1, {7'b1111111, 7'b0000011, 7'b1000000, 7'b1000110}, 4'b1111};
    vecs[6] = '{16'h9ED2, 4'b1111, 4'b0100, 1'b0, {7'b0010000, 7'b1111111, 7'b0100001, 7'b0100100}, 4'b0100};
    rst_n = 1'b0;
    cyc(); cyc();
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    rst_n = 1'b1;
    cyc();
    check("post_rst_an", an, 4'b1110);
    check("post_rst_seg", seg, 7'b1000000);
    check("post_rst_dp", dp, 1'b1);
    for (int v = 0; v < 7; v++) begin
      int cnt [4];
      int fd_cnt;
      cnt = '{default: 0};
      fd_cnt = 0;
      data = vecs[v].data; dp_in = vecs[v].dpi; blank_in = vecs[v].blk; lzb = vecs[v].lz;
      load = 1'b1;
      cyc();
      load = 1'b0;
      repeat (S * D) begin
        cyc();
        check("an_onecold", $countones(~an), 1);
        for (int k = 0; k < D; k++) if (an == ~(4'b1 << k)) begin
          cnt[k]++;
          check($sformatf("vec%0d_seg_d%0d", v, k), seg, vecs[v].seg[7*k +: 7]);
          check($sformatf("vec%0d_dp_d%0d", v, k), dp, vecs[v].dpx[k]);
        end
        fd_cnt += int'(frame_done);
      end
      for (int k = 0; k < D; k++) check($sformatf("vec%0d_hold_d%0d", v, k), cnt[k], S);
      check($sformatf("vec%0d_frames", v), fd_cnt, 1);
    end
    data = 16'h1A3F; dp_in = '0; blank_in = '0; lzb = 1'b0;
    load = 1'b1; cyc(); load = 1'b0;
    seek(S - 1, 1);
    data = 16'h4567; load = 1'b1;
    cyc();
    load = 1'b0;
    check("lt_old_an", an, 4'b1101);
    check("lt_old_seg", seg, 7'b0110000);
    cyc();
    check("lt_new_an", an, 4'b1011);
    check("lt_new_seg", seg, 7'b0010010);
    seek(1, 2);
    rst_n = 1'b0;
    cyc();
    check("mid_rst_an", an, 4'b1111);
    check("mid_rst_seg", seg, 7'b1111111);
    check("mid_rst_fd", frame_done, 1'b0);
    rst_n = 1'b1;
    cyc();
    check("restart_an", an, 4'b1110);
    check("restart_seg", seg, 7'b1000000);
    check("restart_dp", dp, 1'b1);
    begin
      int held;
      held = 1;
      repeat (S) begin
        cyc();
        if (an == 4'b1110) held++;
      end
      check("restart_hold", held, S);
      check("restart_next", an, 4'b1101);
    end
    repeat (600) begin
      for (int k = 0; k < D; k++) data[4*k +: 4] = ($urandom % 2) ? 4'h0 : 4'($urandom % 16);
      dp_in = 4'($urandom);
      blank_in = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0;
      if ($urandom % 16 == 0) lzb = ~lzb;
      load = ($urandom % 6) == 0;
      rst_n = ($urandom % 100) != 0;
      cyc();
    end
    rst_n = 1'b1;
    load = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
